// File: rtl/cpu_defs.sv
// Shared definitions for the LoongArch32 pipeline front end.
package cpu_defs;

    localparam logic [31:0] RESET_PC_DEF   = 32'h1c000000;
    localparam int          INST_W         = 32;
    localparam int          FS_TO_DS_BUS_W = 64;
    localparam logic [31:0] INST_NOP       = 32'h03400000;

    typedef struct packed {
        logic [31:0]       pc;
        logic [INST_W-1:0] inst;
    } fs_to_ds_bus_t;

    // Sequential fetch address; wraps mod 2^32, no alignment check.
    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fs_inst_buf.sv
// Instruction buffer: captures the SRAM word for the IF instruction while ID
// stalls, so the offered instruction stays stable after the SRAM data goes stale.
module fs_inst_buf
    import cpu_defs::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              rdata_fresh,
    input  logic              hold,
    input  logic              flush,
    input  logic [INST_W-1:0] rdata,
    output logic [INST_W-1:0] inst
);

    logic              buf_valid_d, buf_valid_q;
    logic [INST_W-1:0] buf_d, buf_q;

    // Capture only once per stall, and only while rdata still belongs to fs_pc.
    always_comb begin
        buf_valid_d = buf_valid_q;
        buf_d       = buf_q;
        if (flush) begin
            buf_valid_d = 1'b0;
        end else if (hold && rdata_fresh && !buf_valid_q) begin
            buf_valid_d = 1'b1;
            buf_d       = rdata;
        end
    end

    // Control flag is reset; the data word is only meaningful with the flag.
    always_ff @(posedge clk) begin
        if (reset) buf_valid_q <= 1'b0;
        else       buf_valid_q <= buf_valid_d;
    end

    // Data register, no reset needed.
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

    assign inst = buf_valid_q ? buf_q : rdata;

endmodule

// File: rtl/fetch_stage.sv
// Pre-IF + IF stage: nextpc generation, inst SRAM request, IF latch and
// valid/allowin handshake toward ID, with EX branch redirect handling.
module fetch_stage
    import cpu_defs::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ds_allowin,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic        fs_to_ds_valid,
    output logic [31:0] fs_to_ds_pc,
    output logic [31:0] fs_to_ds_inst,
    output logic        inst_sram_en,
    output logic [3:0]  inst_sram_we,
    output logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_wdata,
    input  logic [31:0] inst_sram_rdata
);

    logic        fs_valid_d, fs_valid_q;
    logic [31:0] fs_pc_d, fs_pc_q;
    logic        redir_valid_d, redir_valid_q;
    logic [31:0] redir_pc_d, redir_pc_q;
    logic        rdata_fresh_d, rdata_fresh_q;

    logic        fs_allowin;
    logic [31:0] nextpc;
    logic        buf_hold;
    logic [31:0] fs_inst;
    fs_to_ds_bus_t fs_to_ds_bus;

    // IF never waits on anything but ID, so ready_go is implicitly 1.
    assign fs_allowin = !fs_valid_q || ds_allowin;

    // A live branch beats a parked redirect, which beats sequential flow.
    always_comb begin
        if (br_taken)           nextpc = br_target;
        else if (redir_valid_q) nextpc = redir_pc_q;
        else                    nextpc = pc_plus4(fs_pc_q);
    end

    // IF latch and parked-redirect update.
    always_comb begin
        fs_valid_d    = fs_valid_q;
        fs_pc_d       = fs_pc_q;
        redir_valid_d = redir_valid_q;
        redir_pc_d    = redir_pc_q;
        if (fs_allowin) begin
            fs_valid_d    = 1'b1;
            fs_pc_d       = nextpc;
            redir_valid_d = 1'b0;
        end else if (br_taken) begin
            // Squash the wrong-path instruction; issue the target once IF frees up.
            fs_valid_d    = 1'b0;
            redir_valid_d = 1'b1;
            redir_pc_d    = br_target;
        end
    end

    assign inst_sram_en  = !reset && fs_allowin;
    assign rdata_fresh_d = inst_sram_en;

    // Control state, reset to the pre-first-fetch condition.
    always_ff @(posedge clk) begin
        if (reset) begin
            fs_valid_q    <= 1'b0;
            fs_pc_q       <= RESET_PC - 32'd4;
            redir_valid_q <= 1'b0;
            rdata_fresh_q <= 1'b0;
        end else begin
            fs_valid_q    <= fs_valid_d;
            fs_pc_q       <= fs_pc_d;
            redir_valid_q <= redir_valid_d;
            rdata_fresh_q <= rdata_fresh_d;
        end
    end

    // Redirect address is qualified by redir_valid_q, so it needs no reset.
    always_ff @(posedge clk) begin
        redir_pc_q <= redir_pc_d;
    end

    // Buffer fills only during a plain stall; a stall+branch leaves it alone.
    assign buf_hold = !fs_allowin && !br_taken;

    fs_inst_buf u_inst_buf (
        .clk         (clk),
        .reset       (reset),
        .rdata_fresh (rdata_fresh_q),
        .hold        (buf_hold),
        .flush       (fs_allowin),
        .rdata       (inst_sram_rdata),
        .inst        (fs_inst)
    );

    assign fs_to_ds_bus    = '{pc: fs_pc_q, inst: fs_inst};
    assign fs_to_ds_valid  = fs_valid_q && !br_taken;
    assign fs_to_ds_pc     = fs_to_ds_bus.pc;
    assign fs_to_ds_inst   = fs_to_ds_bus.inst;
    assign inst_sram_we    = 4'b0000;
    assign inst_sram_addr  = nextpc;
    assign inst_sram_wdata = 32'h0;

endmodule
